// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared types and default widths for the LIFO stack path
package lifo_pkg;

  localparam int LIFO_DATA_W = 8;
  localparam int LIFO_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WRITE   = 2'b01,
    READ    = 2'b10,
    CAPTURE = 2'b11
  } lifo_state_t;

endpackage

// File: rtl/lifo_stack_ctrl_if.sv
// rtl/lifo_stack_ctrl_if.sv - request, RAM and status bundle of the stack controller
interface lifo_stack_ctrl_if
  import lifo_pkg::*;
#(
  parameter int DATA_W = LIFO_DATA_W,
  parameter int ADDR_W = LIFO_ADDR_W
);

  logic              push;
  logic              pop;
  logic              clear;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              busy;
  logic              overflow;
  logic              underflow;

  // Requester / RAM side: drives the pulses, switch data and RAM read data.
  modport master (
    output push, pop, clear, din, ram_rdata,
    input  ram_addr, ram_we, ram_wdata, dout, dout_valid,
    input  count, empty, full, busy, overflow, underflow
  );

  // Controller side.
  modport slave (
    input  push, pop, clear, din, ram_rdata,
    output ram_addr, ram_we, ram_wdata, dout, dout_valid,
    output count, empty, full, busy, overflow, underflow
  );

endinterface

// File: rtl/lifo_stack_ctrl.sv
// rtl/lifo_stack_ctrl.sv - stack pointer, RAM sequencing and status flags
module lifo_stack_ctrl
  import lifo_pkg::*;
#(
  parameter int DATA_W = LIFO_DATA_W,
  parameter int ADDR_W = LIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  lifo_stack_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

  lifo_state_t       r_state;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_ram_we;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);

  // Sequencer: IDLE arbitrates clear > pop > push; busy states ignore all requests.
  // ram_we is a registered FSM output that mirrors the WRITE state, so the
  // asynchronous reset drops it together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_wdata      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ram_we     <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      r_ram_we     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.clear) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
          end else if (bus.pop) begin
            if (!w_empty) begin
              r_count <= r_count - C_ONE;
              r_state <= READ;
            end else begin
              r_underflow <= 1'b1;
            end
          end else if (bus.push) begin
            if (!w_full) begin
              r_wdata  <= bus.din;
              r_ram_we <= 1'b1;
              r_state  <= WRITE;
            end else begin
              r_overflow <= 1'b1;
            end
          end
        end
        WRITE: begin
          // Address was the old count during this cycle; bump it on exit.
          r_count <= r_count + C_ONE;
          r_state <= IDLE;
        end
        READ: begin
          // RAM registers the entry at the decremented count this cycle.
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_dout       <= bus.ram_rdata;
          r_dout_valid <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // When count==DEPTH the low bits wrap to 0, but WRITE is unreachable then.
  assign bus.ram_addr   = r_count[ADDR_W-1:0];
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_wdata  = r_wdata;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.count      = r_count;
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;
  assign bus.busy       = (r_state != IDLE);
  assign bus.overflow   = r_overflow;
  assign bus.underflow  = r_underflow;

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// tb/tb_lifo_stack_ctrl.sv - self-checking bench for lifo_stack_ctrl
module tb_lifo_stack_ctrl;
  import lifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lifo_stack_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  lifo_stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External single-port RAM with registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Count write strobes seen between edges.
  int we_total = 0;
  always @(negedge clk) if (bus.ram_we === 1'b1) we_total++;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [DW-1:0] model [$];
  logic          m_ovf  = 1'b0;
  logic          m_udf  = 1'b0;
  logic [DW-1:0] m_dout = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW:0] m_count();
    return (AW+1)'(model.size());
  endfunction

  task automatic model_clear();
    model.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic push_op(input logic [DW-1:0] d, output int we_cycles,
                         output logic [AW-1:0] we_addr, output logic [DW-1:0] we_data);
    we_cycles = 0;
    we_addr   = '0;
    we_data   = '0;
    bus.din  = d;
    bus.push = 1'b1;
    tick();
    bus.push = 1'b0;
    if (bus.ram_we === 1'b1) begin
      we_cycles++;
      we_addr = bus.ram_addr;
      we_data = bus.ram_wdata;
    end
    tick();
    if (bus.ram_we === 1'b1) we_cycles++;
    if (model.size() < DEPTH) model.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic pop_op(output int valid_cycles, output logic valid_at3,
                        output logic [DW-1:0] d_out);
    valid_cycles = 0;
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    if (bus.dout_valid === 1'b1) valid_cycles++;
    tick();
    if (bus.dout_valid === 1'b1) valid_cycles++;
    tick();
    valid_at3 = bus.dout_valid;
    if (bus.dout_valid === 1'b1) valid_cycles++;
    d_out = bus.dout;
    tick();
    if (bus.dout_valid === 1'b1) valid_cycles++;
    if (model.size() > 0) m_dout = model.pop_back();
    else m_udf = 1'b1;
  endtask

  task automatic clear_op();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; bus.din = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags empty=%b full=%b busy=%b exp 1 0 0", bus.empty, bus.full, bus.busy); end
    checks++; if (bus.ram_we !== 1'b0 || bus.ram_wdata !== '0) begin
      errors++; $display("FAIL reset_ram we=%b wdata=%h exp 0 00", bus.ram_we, bus.ram_wdata); end
    checks++; if (bus.dout !== '0 || bus.dout_valid !== 1'b0) begin
      errors++; $display("FAIL reset_dout dout=%h valid=%b exp 00 0", bus.dout, bus.dout_valid); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL reset_sticky ovf=%b udf=%b exp 0 0", bus.overflow, bus.underflow); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_clear();
    m_dout = '0;
  endtask

  task automatic test_single_push();
    int we_c; logic [AW-1:0] a; logic [DW-1:0] d;
    push_op(8'hA5, we_c, a, d);
    checks++; if (we_c !== 1) begin errors++; $display("FAIL push_we_cycles got=%0d exp=1", we_c); end
    checks++; if (a !== '0 || d !== 8'hA5) begin errors++; $display("FAIL push_addr_data addr=%0d data=%h exp 0 a5", a, d); end
    checks++; if (bus.count !== 9'd1 || bus.empty !== 1'b0) begin
      errors++; $display("FAIL push_count count=%0d empty=%b exp 1 0", bus.count, bus.empty); end
  endtask

  task automatic test_push_pop_seq();
    int we_c, vc; logic [AW-1:0] a; logic [DW-1:0] d, exp_d; logic v3;
    logic [DW-1:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    clear_op();
    foreach (vals[i]) push_op(vals[i], we_c, a, d);
    checks++; if (bus.count !== m_count()) begin errors++; $display("FAIL seq_count3 got=%0d exp=%0d", bus.count, m_count()); end
    for (int i = 0; i < 3; i++) begin
      exp_d = model[$];
      pop_op(vc, v3, d);
      checks++; if (d !== exp_d) begin errors++; $display("FAIL seq_pop%0d dout got=%h exp=%h", i, d, exp_d); end
      checks++; if (vc !== 1 || v3 !== 1'b1) begin errors++; $display("FAIL seq_valid%0d pulses=%0d at3=%b exp 1 1", i, vc, v3); end
    end
    checks++; if (bus.count !== '0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL seq_end count=%0d empty=%b exp 0 1", bus.count, bus.empty); end
  endtask

  task automatic test_underflow();
    int vc, we0; logic v3; logic [DW-1:0] d;
    we0 = we_total;
    pop_op(vc, v3, d);
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL udf_set got=%b exp=1", bus.underflow); end
    checks++; if (bus.count !== '0 || vc !== 0 || we_total != we0) begin
      errors++; $display("FAIL udf_side count=%0d valid_pulses=%0d we=%0d exp 0 0 0", bus.count, vc, we_total - we0); end
    clear_op();
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL udf_clear got=%b exp=0", bus.underflow); end
  endtask

  task automatic test_fill_overflow();
    int we_c, vc; logic [AW-1:0] a; logic [DW-1:0] d; logic v3;
    clear_op();
    for (int i = 0; i < DEPTH; i++) push_op(DW'(i * 7 + 3), we_c, a, d);
    checks++; if (bus.full !== 1'b1 || bus.count !== 9'd256) begin
      errors++; $display("FAIL fill_full full=%b count=%0d exp 1 256", bus.full, bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got=%b exp=0", bus.overflow); end
    push_op(8'hEE, we_c, a, d);
    checks++; if (bus.overflow !== 1'b1 || we_c !== 0 || bus.count !== 9'd256) begin
      errors++; $display("FAIL ovf_push ovf=%b we=%0d count=%0d exp 1 0 256", bus.overflow, we_c, bus.count); end
    pop_op(vc, v3, d);
    checks++; if (d !== m_dout || vc !== 1) begin
      errors++; $display("FAIL full_pop dout=%h pulses=%0d exp %h 1", d, vc, m_dout); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_priority();
    int we_c, we0, vc; logic [AW-1:0] a; logic [DW-1:0] d, dout0;
    clear_op();
    push_op(8'h01, we_c, a, d);
    push_op(8'h02, we_c, a, d);
    we0 = we_total; dout0 = bus.dout; vc = 0;
    bus.clear = 1'b1; bus.pop = 1'b1; bus.push = 1'b1; bus.din = 8'h99;
    tick();
    bus.clear = 1'b0; bus.pop = 1'b0; bus.push = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      if (bus.dout_valid === 1'b1) vc++;
      tick();
    end
    checks++; if (bus.count !== '0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL prio_clear count=%0d busy=%b ovf=%b exp 0 0 0", bus.count, bus.busy, bus.overflow); end
    checks++; if (we_total != we0 || vc != 0 || bus.dout !== dout0) begin
      errors++; $display("FAIL prio_dropped we=%0d valid=%0d dout=%h exp 0 0 %h", we_total - we0, vc, bus.dout, dout0); end
  endtask

  task automatic test_back_to_back();
    int we0;
    clear_op();
    we0 = we_total;
    bus.din = 8'h77; bus.push = 1'b1;
    tick();
    bus.din = 8'h88;
    tick();
    bus.push = 1'b0;
    tick();
    model.push_back(8'h77);
    checks++; if (bus.count !== 9'd1 || we_total - we0 != 1 || mem[0] !== 8'h77) begin
      errors++; $display("FAIL busy_push count=%0d we=%0d mem0=%h exp 1 1 77", bus.count, we_total - we0, mem[0]); end
    // Hold pop through READ and CAPTURE; only the first edge is honoured.
    bus.pop = 1'b1;
    repeat (3) tick();
    bus.pop = 1'b0;
    tick();
    m_dout = model.pop_back();
    checks++; if (bus.count !== '0 || bus.underflow !== 1'b0 || bus.dout !== 8'h77) begin
      errors++; $display("FAIL busy_pop count=%0d udf=%b dout=%h exp 0 0 77", bus.count, bus.underflow, bus.dout); end
  endtask

  task automatic test_reset_mid_write();
    int we_c; logic [AW-1:0] a; logic [DW-1:0] d;
    clear_op();
    push_op(8'h10, we_c, a, d);
    bus.din = 8'h3C; bus.push = 1'b1;
    tick();
    bus.push = 1'b0;
    checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL mid_write_we got=%b exp=1", bus.ram_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ram_we !== 1'b0 || bus.count !== '0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL async_reset we=%b count=%0d busy=%b exp 0 0 0", bus.ram_we, bus.count, bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    m_dout = '0;
    tick();
    push_op(8'h5A, we_c, a, d);
    checks++; if (we_c !== 1 || a !== '0 || d !== 8'h5A || bus.count !== 9'd1) begin
      errors++; $display("FAIL post_reset_push we=%0d addr=%0d data=%h count=%0d exp 1 0 5a 1", we_c, a, d, bus.count); end
  endtask

  task automatic test_random();
    int we_c, vc, sel; logic [AW-1:0] a; logic [DW-1:0] d, rd; logic v3; logic had;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        clear_op();
      end else if (sel < 9) begin
        had = (model.size() > 0);
        pop_op(vc, v3, rd);
        checks++; if (vc != (had ? 1 : 0) || (had && rd !== m_dout)) begin
          errors++; $display("FAIL rand_pop%0d pulses=%0d dout=%h exp %0d %h", n, vc, rd, had ? 1 : 0, m_dout); end
      end else begin
        d = DW'($urandom);
        push_op(d, we_c, a, rd);
      end
      checks++; if (bus.count !== m_count() || bus.dout !== m_dout ||
                    bus.overflow !== m_ovf || bus.underflow !== m_udf) begin
        errors++; $display("FAIL rand_state%0d count=%0d dout=%h ovf=%b udf=%b exp %0d %h %b %b",
                           n, bus.count, bus.dout, bus.overflow, bus.underflow, m_count(), m_dout, m_ovf, m_udf); end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_push_pop_seq();
    test_underflow();
    test_fill_overflow();
    test_priority();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
